mips_mem_responder: RTL

Memory-side responder for the multicycle MIPS core's byte-wide memory interface (memread, memwrite, adr, writedata, memdata). It holds a 2^WIDTH-byte unified instruction/data RAM, which a byte-stream loader fills while the block holds the core in reset. After loading, it releases the core and serves its reads and writes with zero wait states. One address is mapped to an I/O port instead of RAM.

---
 rtl/mips_mem_responder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mips_mem_responder.sv
// Byte-wide memory responder for the multicycle MIPS core: loads a program image
// while holding the core in reset, then serves zero-wait-state reads/writes plus one I/O port.
module mips_mem_responder #(
  parameter int unsigned           WIDTH   = 8,
  parameter logic [WIDTH-1:0]      IO_ADDR = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] memdata,
  input  logic             load_valid,
  input  logic [7:0]       load_data,
  output logic             load_ready,
  input  logic             load_done,
  output logic             cpu_reset,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  output logic             io_strobe
);

  localparam logic [1:0] S_LOAD    = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;

  localparam int unsigned DEPTH    = 1 << WIDTH;
  localparam logic [WIDTH:0] LAST_PTR = (WIDTH+1)'(DEPTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH:0]   r_load_ptr;
  logic [WIDTH-1:0] r_io_out;
  logic             r_io_strobe;
  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  logic             w_load_acc;
  logic             w_io_hit;
  logic             w_we;
  logic [WIDTH-1:0] w_waddr;
  logic [WIDTH-1:0] w_wdata;

  assign w_load_acc = (r_state == S_LOAD) & load_valid;
  assign w_io_hit   = (adr == IO_ADDR);

  // Single RAM write port shared by the loader and the running core
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (reset) begin
      w_we = 1'b0;
    end else if (w_load_acc) begin
      w_we    = 1'b1;
      w_waddr = r_load_ptr[WIDTH-1:0];
      w_wdata = WIDTH'(load_data);
    end else if ((r_state == S_RUN) && memwrite && !w_io_hit) begin
      w_we    = 1'b1;
      w_waddr = adr;
      w_wdata = writedata;
    end else begin
      w_we = 1'b0;
    end
  end

  // RAM array; deliberately not cleared by reset so a loaded image survives
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Phase sequencing and loader pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_LOAD;
      r_load_ptr <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_load_acc) begin
            r_load_ptr <= r_load_ptr + (WIDTH+1)'(1);
          end
          // the terminal byte ends loading so the pointer never wraps back to zero
          if (load_done || (w_load_acc && (r_load_ptr == LAST_PTR))) begin
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: r_state <= S_RUN;
        S_RUN:     r_state <= S_RUN;
        default:   r_state <= S_LOAD;
      endcase
    end
  end

  // I/O port register and its one-cycle write strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_io_out    <= '0;
      r_io_strobe <= 1'b0;
    end else if ((r_state == S_RUN) && memwrite && w_io_hit) begin
      r_io_out    <= writedata;
      r_io_strobe <= 1'b1;
    end else begin
      r_io_strobe <= 1'b0;
    end
  end

  // Read data is combinational: the core latches it at the end of the same cycle
  always_comb begin
    memdata = '0;
    if ((r_state == S_RUN) && memread) begin
      if (w_io_hit) begin
        memdata = io_in;
      end else begin
        memdata = r_mem[adr];
      end
    end else begin
      memdata = '0;
    end
  end

  assign load_ready = (r_state == S_LOAD);
  assign cpu_reset  = (r_state != S_RUN);
  assign io_out     = r_io_out;
  assign io_strobe  = r_io_strobe;

endmodule
